ex_mem_pipeline_buffer: RTL and testbench
=========================================

Name: ex_mem_pipeline_buffer

Overview:
Parametrised EX→MEM pipeline buffer: a DEPTH-entry FIFO of execute-stage results with a valid/ready handshake on both sides. It blocks issuing memory operations while MAX_OUTSTANDING data-cache accesses are unacknowledged. It supports pipeline stall and flush. It sits between the ALU/execute stage and the data-cache/memory stage and replaces a single-entry lock-based register.

Parameters:
WORD_WIDTH, 32, data/instruction word width
REGISTER_INDEX_WIDTH, 5, register index width
DEPTH, 2, FIFO entries; power of two, >=2
MAX_OUTSTANDING, 1, issued d-cache accesses allowed without mem_done; >=1

Ports:
clk  in  1  clock; all state updates on falling edge
rst  in  1  synchronous active-high reset, sampled on falling edge of clk
in_valid  in  1  execute stage presents an entry
in_ready  out  1  buffer can accept: ~full & ~stall & ~flush
instruction_in, alu_result_in, extended_inmediate_in, second_register_in  in  WORD_WIDTH each  payload words
destination_register_in  in  REGISTER_INDEX_WIDTH  destination register
alu_zero_in, cu_mem_to_reg_in, cu_reg_write_in, cu_d_cache_access_in, cu_d_cache_op_in, cu_is_byte_op_in  in  1 each  payload flags
out_valid  out  1  head entry is valid and issuable
out_ready  in  1  memory stage takes head entry
<field>_out  out  same widths as inputs  head-entry payload
mem_done  in  1  pulse: one issued d-cache access completed
stall  in  1  freeze enqueue and dequeue
flush  in  1  discard all queued entries
count  out  clog2(DEPTH)+1  entries held
outstanding  out  clog2(MAX_OUTSTANDING+1)  issued, uncompleted d-cache accesses

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
- Enqueue when in_valid & in_ready. The whole payload is written at wr_ptr, and wr_ptr and count are incremented.
- Latency: an entry enqueued at edge N appears on the outputs after edge N. There is no combinational bypass, so an empty buffer never forwards inputs.
- Issue gating:
  - head_is_mem = head cu_d_cache_access.
  - blocked = head_is_mem & (outstanding==MAX_OUTSTANDING).
  - out_valid = ~empty & ~blocked & ~stall & ~flush.
- Dequeue when out_valid & out_ready. rd_ptr is incremented and count is decremented. If the dequeued entry has head_is_mem set, outstanding is incremented.
- outstanding decrements on mem_done, with these rules:
  - mem_done when outstanding==0 is ignored.
  - A mem-op dequeue and mem_done in the same cycle leave outstanding unchanged.
  - mem_done is honoured during stall and flush.
- Enqueue and dequeue in the same cycle: count is unchanged. This is legal when full, but in_ready is already 0 when full, so there is no same-cycle refill.
- *_out fields are driven from the head slot whenever ~empty. When empty they hold 0.
  - Consumers qualify all outputs with out_valid.
  - When blocked, the fields still show the head entry but out_valid=0.
- stall: no enqueue or dequeue; state is held; in_ready=0 and out_valid=0.
- flush: count, wr_ptr and rd_ptr are cleared and all entries are dropped. Any enqueue attempted that cycle is dropped. flush has priority over stall. outstanding is NOT cleared, because issued accesses still complete.
- rst: priority over everything; takes effect mid-operation, including with outstanding>0.
  - count=0, pointers=0, outstanding=0, all storage and *_out=0.
  - out_valid=0.
  - in_ready=1 in the cycle after reset deasserts, if stall=0.
- Widths: count needs clog2(DEPTH)+1 bits so that DEPTH is representable. Pointers are clog2(DEPTH) bits.

Test Plan:
- Reset, then enqueue 3 entries (alu_result 0x11,0x22,0x33) with out_ready=0 and DEPTH=2 → 0x11,0x22 accepted. in_ready=0 on the third; count=2.
- Set out_ready=1 → outputs 0x11 then 0x22 on consecutive cycles. 0x33 is accepted once space frees; FIFO order is preserved across pointer wrap.
- With MAX_OUTSTANDING=1, enqueue two d-cache entries (0xA0,0xA4) and hold mem_done=0 → 0xA0 issues and outstanding=1. 0xA4 sits with out_valid=0. A mem_done pulse → 0xA4 issues next cycle and outstanding stays 1.
- mem_done asserted in the same cycle as a mem-op dequeue → outstanding unchanged. mem_done with outstanding=0 → remains 0.
- Assert stall for 3 cycles with 1 entry queued and in_valid=1 → no enqueue or dequeue and count constant. Deassert stall → normal flow resumes.
- With 2 entries queued and outstanding=1: assert flush together with in_valid → count=0, out_valid=0, outstanding=1. The next mem_done takes outstanding to 0. Assert rst mid-traffic → all outputs 0.

Source files
------------

// File: rtl/ex_mem_pipeline_buffer.sv
// ex_mem_pipeline_buffer
// EX->MEM pipeline buffer: a DEPTH-entry FIFO of execute-stage results with
// valid/ready handshakes on both sides. Issue of a data-cache access is held
// back while MAX_OUTSTANDING accesses are still waiting for mem_done.
// All state changes on the falling edge of clk.
//
// Ports
//   clk, rst                 clock (falling-edge active), sync active-high reset
//   in_valid / in_ready      enqueue handshake from the execute stage
//   *_in                     entry payload (words, register index, control flags)
//   out_valid / out_ready    dequeue handshake to the memory stage
//   *_out                    head-entry payload (zero when empty)
//   mem_done                 pulse: one issued d-cache access completed
//   stall                    freeze enqueue and dequeue
//   flush                    drop every queued entry
//   count                    entries currently held
//   outstanding              issued d-cache accesses not yet completed
module ex_mem_pipeline_buffer #(
  parameter int WORD_WIDTH           = 32,
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int DEPTH                = 2,
  parameter int MAX_OUTSTANDING      = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WORD_WIDTH-1:0]                  instruction_in,
  input  logic [WORD_WIDTH-1:0]                  alu_result_in,
  input  logic [WORD_WIDTH-1:0]                  extended_inmediate_in,
  input  logic [WORD_WIDTH-1:0]                  second_register_in,
  input  logic [REGISTER_INDEX_WIDTH-1:0]        destination_register_in,
  input  logic                                   alu_zero_in,
  input  logic                                   cu_mem_to_reg_in,
  input  logic                                   cu_reg_write_in,
  input  logic                                   cu_d_cache_access_in,
  input  logic                                   cu_d_cache_op_in,
  input  logic                                   cu_is_byte_op_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [WORD_WIDTH-1:0]                  instruction_out,
  output logic [WORD_WIDTH-1:0]                  alu_result_out,
  output logic [WORD_WIDTH-1:0]                  extended_inmediate_out,
  output logic [WORD_WIDTH-1:0]                  second_register_out,
  output logic [REGISTER_INDEX_WIDTH-1:0]        destination_register_out,
  output logic                                   alu_zero_out,
  output logic                                   cu_mem_to_reg_out,
  output logic                                   cu_reg_write_out,
  output logic                                   cu_d_cache_access_out,
  output logic                                   cu_d_cache_op_out,
  output logic                                   cu_is_byte_op_out,
  input  logic                                   mem_done,
  input  logic                                   stall,
  input  logic                                   flush,
  output logic [$clog2(DEPTH):0]                 count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [WORD_WIDTH-1:0]           instruction;
    logic [WORD_WIDTH-1:0]           alu_result;
    logic [WORD_WIDTH-1:0]           ext_imm;
    logic [WORD_WIDTH-1:0]           second_reg;
    logic [REGISTER_INDEX_WIDTH-1:0] dest;
    logic                            alu_zero;
    logic                            mem_to_reg;
    logic                            reg_write;
    logic                            d_cache_access;
    logic                            d_cache_op;
    logic                            is_byte;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           wr_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             blocked;
  logic             enq;
  logic             deq;
  logic             mem_issue;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign blocked = head.d_cache_access & (outstanding == OUT_W'(MAX_OUTSTANDING));

  assign in_ready  = ~full & ~stall & ~flush;
  assign out_valid = ~empty & ~blocked & ~stall & ~flush;
  assign enq       = in_valid & in_ready;
  assign deq       = out_valid & out_ready;
  assign mem_issue = deq & head.d_cache_access;

  always_comb begin
    wr_entry                = '0;
    wr_entry.instruction    = instruction_in;
    wr_entry.alu_result     = alu_result_in;
    wr_entry.ext_imm        = extended_inmediate_in;
    wr_entry.second_reg     = second_register_in;
    wr_entry.dest           = destination_register_in;
    wr_entry.alu_zero       = alu_zero_in;
    wr_entry.mem_to_reg     = cu_mem_to_reg_in;
    wr_entry.reg_write      = cu_reg_write_in;
    wr_entry.d_cache_access = cu_d_cache_access_in;
    wr_entry.d_cache_op     = cu_d_cache_op_in;
    wr_entry.is_byte        = cu_is_byte_op_in;
  end

  // Flush leaves stale slots in storage, so the head view is masked when empty.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr];
  end

  assign instruction_out          = head.instruction;
  assign alu_result_out           = head.alu_result;
  assign extended_inmediate_out   = head.ext_imm;
  assign second_register_out      = head.second_reg;
  assign destination_register_out = head.dest;
  assign alu_zero_out             = head.alu_zero;
  assign cu_mem_to_reg_out        = head.mem_to_reg;
  assign cu_reg_write_out         = head.reg_write;
  assign cu_d_cache_access_out    = head.d_cache_access;
  assign cu_d_cache_op_out        = head.d_cache_op;
  assign cu_is_byte_op_out        = head.is_byte;

  always_ff @(negedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[PTR_W'(i)] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          mem[wr_ptr] <= wr_entry;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        if (enq && !deq)      count <= count + 1'b1;
        else if (!enq && deq) count <= count - 1'b1;
      end
      // Completions are counted even under stall/flush: issued accesses
      // still finish. A same-cycle issue and completion cancel out.
      if (mem_issue && !mem_done)
        outstanding <= outstanding + 1'b1;
      else if (!mem_issue && mem_done && outstanding != '0)
        outstanding <= outstanding - 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_pipeline_buffer.sv
module tb_ex_mem_pipeline_buffer;

  localparam int DEPTH_TB = 2;
  localparam int MAXO_TB  = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, mem_done, stall, flush;
  logic [31:0] instruction_in, alu_result_in, extended_inmediate_in, second_register_in;
  logic [4:0]  destination_register_in;
  logic        alu_zero_in, cu_mem_to_reg_in, cu_reg_write_in;
  logic        cu_d_cache_access_in, cu_d_cache_op_in, cu_is_byte_op_in;
  logic [31:0] instruction_out, alu_result_out, extended_inmediate_out, second_register_out;
  logic [4:0]  destination_register_out;
  logic        alu_zero_out, cu_mem_to_reg_out, cu_reg_write_out;
  logic        cu_d_cache_access_out, cu_d_cache_op_out, cu_is_byte_op_out;
  logic [1:0]  count;
  logic [0:0]  outstanding;

  ex_mem_pipeline_buffer #(
    .WORD_WIDTH(32), .REGISTER_INDEX_WIDTH(5), .DEPTH(DEPTH_TB), .MAX_OUTSTANDING(MAXO_TB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .alu_result_in(alu_result_in),
    .extended_inmediate_in(extended_inmediate_in), .second_register_in(second_register_in),
    .destination_register_in(destination_register_in), .alu_zero_in(alu_zero_in),
    .cu_mem_to_reg_in(cu_mem_to_reg_in), .cu_reg_write_in(cu_reg_write_in),
    .cu_d_cache_access_in(cu_d_cache_access_in), .cu_d_cache_op_in(cu_d_cache_op_in),
    .cu_is_byte_op_in(cu_is_byte_op_in), .out_valid(out_valid), .out_ready(out_ready),
    .instruction_out(instruction_out), .alu_result_out(alu_result_out),
    .extended_inmediate_out(extended_inmediate_out), .second_register_out(second_register_out),
    .destination_register_out(destination_register_out), .alu_zero_out(alu_zero_out),
    .cu_mem_to_reg_out(cu_mem_to_reg_out), .cu_reg_write_out(cu_reg_write_out),
    .cu_d_cache_access_out(cu_d_cache_access_out), .cu_d_cache_op_out(cu_d_cache_op_out),
    .cu_is_byte_op_out(cu_is_byte_op_out), .mem_done(mem_done), .stall(stall),
    .flush(flush), .count(count), .outstanding(outstanding)
  );

  // flags: {is_byte, d_cache_op, d_cache_access, reg_write, mem_to_reg, alu_zero}
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] sreg;
    logic [4:0]  dest;
    logic [5:0]  flags;
  } ent_t;

  ent_t m_q[$];    // model of FIFO contents
  ent_t exp_q[$];  // expected dequeued entries, in order
  ent_t obs_q[$];  // entries the DUT actually handed over
  ent_t cur;
  int   m_out    = 0;
  bit   last_enq = 0;
  int   checks   = 0;
  int   errors   = 0;

  function automatic ent_t mk(input logic [31:0] a, input bit is_mem);
    ent_t e;
    e.instr = a ^ 32'hC0DE_0000;
    e.alu   = a;
    e.imm   = ~a;
    e.sreg  = a + 32'h100;
    e.dest  = a[4:0] ^ 5'h1f;
    e.flags = {a[1], is_mem ? a[0] : 1'b0, is_mem, a[2], a[3], (a == 32'd0)};
    return e;
  endfunction

  task automatic drive(input ent_t e);
    cur                     = e;
    instruction_in          = e.instr;
    alu_result_in           = e.alu;
    extended_inmediate_in   = e.imm;
    second_register_in      = e.sreg;
    destination_register_in = e.dest;
    {cu_is_byte_op_in, cu_d_cache_op_in, cu_d_cache_access_in,
     cu_reg_write_in, cu_mem_to_reg_in, alu_zero_in} = e.flags;
  endtask

  function automatic ent_t dut_ent();
    ent_t e;
    e.instr = instruction_out;
    e.alu   = alu_result_out;
    e.imm   = extended_inmediate_out;
    e.sreg  = second_register_out;
    e.dest  = destination_register_out;
    e.flags = {cu_is_byte_op_out, cu_d_cache_op_out, cu_d_cache_access_out,
               cu_reg_write_out, cu_mem_to_reg_out, alu_zero_out};
    return e;
  endfunction

  function automatic bit e_in_ready();
    return (m_q.size() < DEPTH_TB) && !stall && !flush;
  endfunction

  function automatic bit e_out_valid();
    bit blk;
    blk = (m_q.size() > 0) && m_q[0].flags[3] && (m_out == MAXO_TB);
    return (m_q.size() > 0) && !blk && !stall && !flush;
  endfunction

  // Advance one active (falling) edge, updating the reference model from the
  // inputs held during that cycle; returns at negedge+1.
  task automatic tick();
    bit ei, eo, enq, deq, inc;
    @(posedge clk);
    ei = e_in_ready();
    eo = e_out_valid();
    last_enq = 0;
    if (rst) begin
      m_q.delete();
      m_out = 0;
    end else begin
      if (out_valid && out_ready) obs_q.push_back(dut_ent());
      enq = in_valid && ei;
      deq = eo && out_ready;
      inc = 0;
      if (deq) begin
        inc = m_q[0].flags[3];
        exp_q.push_back(m_q.pop_front());
      end
      if (flush) m_q.delete();
      else if (enq) begin
        m_q.push_back(cur);
        last_enq = 1;
      end
      if (inc && !mem_done) m_out++;
      else if (!inc && mem_done && m_out > 0) m_out--;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick();
    checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (outstanding !== 1'b0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
    checks++; if (dut_ent() !== '0) begin errors++; $display("FAIL reset_fields: got %h expected 0", dut_ent()); end
    rst = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_fill();
    logic [31:0] vals [3] = '{32'h11, 32'h22, 32'h33};
    out_ready = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(vals[i], 0)); #1;
      checks++;
      if (in_ready !== (i < 2)) begin errors++; $display("FAIL fill_in_ready_%0d: got %b expected %b", i, in_ready, (i < 2)); end
      if (i < 2) tick();
    end
    checks++; if (count !== 2'(m_q.size()) || count !== 2'd2) begin errors++; $display("FAIL fill_count: got %0d expected 2", count); end
    checks++; if (out_valid !== 1'b1 || alu_result_out !== 32'h11) begin errors++; $display("FAIL fill_head: got v=%b %h expected v=1 00000011", out_valid, alu_result_out); end
  endtask

  task automatic test_drain();
    logic [31:0] want [3] = '{32'h11, 32'h22, 32'h33};
    ent_t o, x;
    out_ready = 1;
    tick();
    checks++; if (count !== 2'd1 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_first: got count=%0d rdy=%b expected count=1 rdy=1", count, in_ready); end
    for (int c = 0; c < 6 && (m_q.size() > 0 || in_valid); c++) begin
      tick();
      if (last_enq) in_valid = 0;
    end
    checks++; if (obs_q.size() != exp_q.size() || exp_q.size() != 3) begin errors++; $display("FAIL drain_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < 3 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (o !== x || o.alu !== want[i]) begin errors++; $display("FAIL drain_order_%0d: got %h expected %h", i, o, x); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mem_gating();
    ent_t o, x;
    out_ready = 0; in_valid = 1;
    drive(mk(32'hA0, 1)); tick();
    drive(mk(32'hA4, 1)); tick();
    in_valid = 0; out_ready = 1; mem_done = 0; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gate_first_valid: got %b expected 1", out_valid); end
    tick();
    checks++; if (outstanding !== 1'b1 || m_out != 1) begin errors++; $display("FAIL gate_outstanding: got %0d expected 1", outstanding); end
    checks++; if (out_valid !== 1'b0 || alu_result_out !== 32'hA4) begin errors++; $display("FAIL gate_blocked: got v=%b %h expected v=0 000000a4", out_valid, alu_result_out); end
    tick(); tick();
    mem_done = 1; #1;
    checks++; if (out_valid !== 1'b0 || count !== 2'd1) begin errors++; $display("FAIL gate_hold: got v=%b count=%0d expected v=0 count=1", out_valid, count); end
    tick(); mem_done = 0; #1;
    checks++; if (outstanding !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL gate_release: got out=%0d v=%b expected out=0 v=1", outstanding, out_valid); end
    tick();
    checks++; if (outstanding !== 1'(m_out) || outstanding !== 1'b1 || count !== 2'd0) begin errors++; $display("FAIL gate_second_issue: got out=%0d count=%0d expected out=1 count=0", outstanding, count); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (o !== x) begin errors++; $display("FAIL gate_data: got %h expected %h", o, x); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL gate_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_same_cycle();
    mem_done = 1; tick(); mem_done = 0;
    checks++; if (outstanding !== 1'b0) begin errors++; $display("FAIL done_dec: got %0d expected 0", outstanding); end
    out_ready = 0; in_valid = 1; drive(mk(32'hB0, 1)); tick();
    in_valid = 0; out_ready = 1; mem_done = 1; #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %b expected 1", out_valid); end
    tick(); mem_done = 0;
    checks++; if (outstanding !== 1'(m_out) || outstanding !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL same_cycle: got out=%0d count=%0d expected out=0 count=0", outstanding, count); end
    mem_done = 1; tick(); mem_done = 0;
    checks++; if (outstanding !== 1'b0) begin errors++; $display("FAIL done_at_zero: got %0d expected 0", outstanding); end
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL same_data: got %0d items expected %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    ent_t o, x;
    out_ready = 0; in_valid = 1; drive(mk(32'h55, 0)); tick();
    drive(mk(32'h66, 0)); stall = 1; out_ready = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_hs_%0d: got rdy=%b v=%b expected 0 0", c, in_ready, out_valid); end
      tick();
      checks++; if (count !== 2'd1) begin errors++; $display("FAIL stall_count_%0d: got %0d expected 1", c, count); end
    end
    stall = 0;
    for (int c = 0; c < 6 && (m_q.size() > 0 || in_valid); c++) begin
      tick();
      if (last_enq) in_valid = 0;
    end
    checks++; if (obs_q.size() != 2 || exp_q.size() != 2) begin errors++; $display("FAIL stall_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (o !== x) begin errors++; $display("FAIL stall_data: got %h expected %h", o, x); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1; drive(mk(32'hD0, 1)); tick();
    in_valid = 0; out_ready = 1; tick();
    out_ready = 0; in_valid = 1;
    drive(mk(32'h70, 0)); tick();
    drive(mk(32'h74, 0)); tick();
    drive(mk(32'h78, 0)); flush = 1; #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL flush_during: got rdy=%b v=%b count=%0d expected 0 0 2", in_ready, out_valid, count); end
    tick(); flush = 0; in_valid = 0; #1;
    checks++; if (count !== 2'd0 || out_valid !== 1'b0 || alu_result_out !== 32'h0) begin errors++; $display("FAIL flush_after: got count=%0d v=%b alu=%h expected 0 0 0", count, out_valid, alu_result_out); end
    checks++; if (outstanding !== 1'(m_out) || outstanding !== 1'b1) begin errors++; $display("FAIL flush_outstanding: got %0d expected 1", outstanding); end
    mem_done = 1; tick(); mem_done = 0;
    checks++; if (outstanding !== 1'b0) begin errors++; $display("FAIL flush_done: got %0d expected 0", outstanding); end
    checks++; if (obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL flush_data: got %0d items expected %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    out_ready = 0; in_valid = 1;
    drive(mk(32'hE0, 1)); tick();
    drive(mk(32'hE4, 1)); tick();
    in_valid = 0; out_ready = 1; tick();
    checks++; if (outstanding !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL mid_pre: got out=%0d count=%0d expected 1 1", outstanding, count); end
    rst = 1; in_valid = 1; drive(mk(32'hE8, 0)); tick();
    checks++; if (count !== 2'd0 || outstanding !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_state: got count=%0d out=%0d v=%b expected 0 0 0", count, outstanding, out_valid); end
    checks++; if (dut_ent() !== '0) begin errors++; $display("FAIL mid_reset_fields: got %h expected 0", dut_ent()); end
    rst = 0; in_valid = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; mem_done = 0; stall = 0; flush = 0;
    drive(mk(32'h0, 0));
    test_reset();
    test_fill();
    test_drain();
    test_mem_gating();
    test_same_cycle();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
